mpu_det_sequencer: RTL and testbench

Front-end sequencer for the MPU determinant stage. It accepts a job (size n = 1..5) and n*n signed int8 elements over a valid/ready stream in row-major order, and packs them into the 5x5 matrix bus. It holds the matrix and size stable for a fixed settle time, then captures the determinant result. The captured result is offered to the consumer on a valid/ready handshake.

---
 rtl/mpu_det_sequencer.sv | 131 +++++++++++++
 tb/tb_mpu_det_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mpu_det_sequencer.sv
// Front-end sequencer for the MPU determinant stage: loads an n x n int8 matrix, settles, captures det.
// Latency: DET_LATENCY+1 cycles from last element accept to result_valid; result held until result_ready.
module mpu_det_sequencer #(
    parameter int DET_LATENCY = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         start,
    input  logic         abort,
    input  logic [7:0]   size_in,
    input  logic [7:0]   elem_data,
    input  logic         elem_valid,
    output logic         elem_ready,
    output logic [0:199] matrix,
    output logic [7:0]   size,
    input  logic [7:0]   det_result,
    output logic         busy,
    output logic         error,
    output logic [7:0]   result,
    output logic         result_valid,
    input  logic         result_ready
);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT, RESULT} state_t;

    localparam logic [7:0] WAIT_LAST = 8'(DET_LATENCY - 1);

    state_t     state, state_nxt;
    logic [2:0] row, col;
    logic [7:0] wait_cnt;
    logic [2:0] last_idx;
    logic [4:0] elem_idx;
    logic [7:0] bit_base;
    logic       size_ok;
    logic       accept;
    logic       last_elem;
    logic       capture;

    // Unsigned compare also rejects negative sizes, whose MSB pushes them above 5.
    assign size_ok   = (size_in >= 8'd1) && (size_in <= 8'd5);
    assign last_idx  = size[2:0] - 3'd1;
    assign accept    = (state == LOAD) && elem_valid;
    assign last_elem = accept && (row == last_idx) && (col == last_idx);
    assign capture   = (state == WAIT) && (wait_cnt == WAIT_LAST);
    assign elem_idx  = 5'd5 * {2'b00, row} + {2'b00, col};
    assign bit_base  = {elem_idx, 3'b000};

    always_comb begin
        state_nxt  = state;
        elem_ready = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start && size_ok) state_nxt = LOAD;
            end
            LOAD: begin
                elem_ready = 1'b1;
                if (last_elem) state_nxt = WAIT;
            end
            WAIT:   if (capture) state_nxt = RESULT;
            RESULT: if (result_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            matrix       <= '0;
            size         <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            error        <= 1'b0;
            row          <= '0;
            col          <= '0;
            wait_cnt     <= '0;
        end else begin
            error <= 1'b0;
            if (abort) begin
                // matrix and size deliberately survive an abort
                row          <= '0;
                col          <= '0;
                wait_cnt     <= '0;
                result_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if (size_ok) begin
                                matrix <= '0;
                                size   <= size_in;
                                row    <= '0;
                                col    <= '0;
                            end else begin
                                error <= 1'b1;
                            end
                        end
                    end
                    LOAD: begin
                        if (accept) begin
                            matrix[bit_base +: 8] <= elem_data;
                            if (col == last_idx) begin
                                col <= '0;
                                row <= row + 3'd1;
                            end else begin
                                col <= col + 3'd1;
                            end
                            if (last_elem) wait_cnt <= '0;
                        end
                    end
                    WAIT: begin
                        wait_cnt <= wait_cnt + 8'd1;
                        if (capture) begin
                            result       <= det_result;
                            result_valid <= 1'b1;
                        end
                    end
                    RESULT: if (result_ready) result_valid <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mpu_det_sequencer.sv
// Scoreboard bench for mpu_det_sequencer with a behavioural determinant stage.
// Expected determinants are queued when a job is loaded and popped on each result handshake.
module tb_mpu_det_sequencer;

    localparam int DL = 8;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         start, abort;
    logic [7:0]   size_in, elem_data;
    logic         elem_valid, elem_ready;
    logic [0:199] matrix;
    logic [7:0]   size;
    logic [7:0]   det_result;
    logic         busy, error;
    logic [7:0]   result;
    logic         result_valid, result_ready;

    int           checks = 0;
    int           errors = 0;
    logic [7:0]   exp_q[$];
    int           job_el[25];
    logic [0:199] exp_mat;

    mpu_det_sequencer #(.DET_LATENCY(DL)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
        .size_in(size_in), .elem_data(elem_data), .elem_valid(elem_valid),
        .elem_ready(elem_ready), .matrix(matrix), .size(size),
        .det_result(det_result), .busy(busy), .error(error), .result(result),
        .result_valid(result_valid), .result_ready(result_ready)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [199:0] got, input logic [199:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Integer determinant by fraction-free elimination over the packed bus.
    function automatic int det_fn(input logic [0:199] mat, input int n);
        longint m[5][5];
        longint prev, t;
        int     sgn, p;
        logic [7:0] b;
        if (n < 1 || n > 5) return 0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) begin
                b = mat[8*(c+5*r) +: 8];
                m[r][c] = longint'($signed(b));
            end
        prev = 1;
        sgn  = 1;
        for (int k = 0; k < n - 1; k++) begin
            if (m[k][k] == 0) begin
                p = -1;
                for (int i = k + 1; i < n; i++)
                    if (p < 0 && m[i][k] != 0) p = i;
                if (p < 0) return 0;
                for (int j = 0; j < n; j++) begin
                    t = m[k][j]; m[k][j] = m[p][j]; m[p][j] = t;
                end
                sgn = -sgn;
            end
            for (int i = k + 1; i < n; i++)
                for (int j = k + 1; j < n; j++)
                    m[i][j] = (m[i][j] * m[k][k] - m[i][k] * m[k][j]) / prev;
            prev = m[k][k];
        end
        return sgn * int'(m[n-1][n-1]);
    endfunction

    always_comb det_result = 8'(det_fn(matrix, int'(size)));

    always @(negedge clock) begin
        if (reset_n && result_valid && result_ready) begin
            if (exp_q.size() == 0) check("unexpected_result", 200'd1, 200'd0);
            else                   check("result", result, exp_q.pop_front());
        end
    end

    task automatic load_job(input int n, input bit gap, input int stop_after);
        int accepted, cyc, busy_bad;
        bit acc;
        exp_mat = '0;
        for (int k = 0; k < n * n; k++)
            exp_mat[8*((k % n) + 5*(k / n)) +: 8] = 8'(job_el[k]);
        size_in = 8'(n);
        start   = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        check("load_entry_ready", elem_ready, 1'b1);
        accepted = 0; cyc = 0; busy_bad = 0;
        while (accepted < stop_after && cyc < 500) begin
            elem_valid = gap ? (cyc % 2 == 0) : 1'b1;
            elem_data  = 8'(job_el[accepted]);
            acc = elem_valid && elem_ready;
            if (!busy) busy_bad++;
            @(posedge clock); #1;
            cyc++;
            if (acc) accepted++;
        end
        elem_valid = 1'b0;
        check("load_accepts", accepted, stop_after);
        check("load_busy", busy_bad, 0);
        if (stop_after == n * n) begin
            check("load_matrix", matrix, exp_mat);
            check("load_done_ready", elem_ready, 1'b0);
            exp_q.push_back(8'(det_fn(exp_mat, n)));
        end
    endtask

    task automatic wait_result();
        int k;
        k = 1;
        while (!result_valid && k < DL + 20) begin
            @(posedge clock); #1;
            k++;
        end
        check("result_latency", k, DL + 1);
    endtask

    task automatic consume();
        result_ready = 1'b1;
        @(posedge clock); #1;
        result_ready = 1'b0;
        check("valid_drop", result_valid, 1'b0);
        check("idle_after_result", busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=1 exp=0");
        $fatal(1, "timeout");
    end

    initial begin
        int bad, seen;
        logic [7:0] bad_sizes[3];
        bad_sizes[0] = 8'd6; bad_sizes[1] = 8'd0; bad_sizes[2] = 8'hFD;

        reset_n = 1'b0; start = 1'b0; abort = 1'b0; size_in = '0;
        elem_data = '0; elem_valid = 1'b0; result_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_matrix", matrix, '0);
        check("rst_size", size, 8'd0);
        check("rst_result", result, 8'd0);
        check("rst_valid", result_valid, 1'b0);
        check("rst_ready", elem_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_error", error, 1'b0);
        reset_n = 1'b1;
        @(posedge clock); #1;

        // 2x2: 3 1 / 2 4 -> det 10
        job_el[0] = 3; job_el[1] = 1; job_el[2] = 2; job_el[3] = 4;
        load_job(2, 1'b0, 4);
        check("m2_b00", matrix[0:7], 8'd3);
        check("m2_b01", matrix[8:15], 8'd1);
        check("m2_b10", matrix[40:47], 8'd2);
        check("m2_b11", matrix[48:55], 8'd4);
        check("m2_size", size, 8'd2);
        wait_result();
        check("m2_result", result, 8'd10);
        consume();

        // 5x5 with gapped valid, element k = k+1
        for (int k = 0; k < 25; k++) job_el[k] = k + 1;
        load_job(5, 1'b1, 25);
        check("m5_last", matrix[192:199], 8'd25);
        wait_result();
        consume();

        // illegal sizes
        foreach (bad_sizes[i]) begin
            size_in = bad_sizes[i];
            start   = 1'b1;
            @(posedge clock); #1;
            start = 1'b0;
            check("err_pulse", error, 1'b1);
            check("err_busy", busy, 1'b0);
            check("err_ready", elem_ready, 1'b0);
            check("err_size", size, 8'd5);
            @(posedge clock); #1;
            check("err_clear", error, 1'b0);
            check("err_stay_idle", busy, 1'b0);
        end

        // 3x3 diag 2 held by backpressure
        for (int k = 0; k < 25; k++) job_el[k] = 0;
        job_el[0] = 2; job_el[4] = 2; job_el[8] = 2;
        load_job(3, 1'b0, 9);
        wait_result();
        bad = 0;
        repeat (4) begin
            @(posedge clock); #1;
            if (!result_valid || result !== 8'd8) bad++;
        end
        check("hold_stable", bad, 0);
        consume();

        // reset after 2 of 4 elements
        job_el[0] = 1; job_el[1] = 2; job_el[2] = 3; job_el[3] = 4;
        load_job(2, 1'b0, 2);
        reset_n = 1'b0;
        #1;
        check("arst_matrix", matrix, '0);
        check("arst_size", size, 8'd0);
        check("arst_result", result, 8'd0);
        check("arst_busy", busy, 1'b0);
        check("arst_ready", elem_ready, 1'b0);
        check("arst_valid", result_valid, 1'b0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;
        job_el[0] = -5;
        load_job(1, 1'b0, 1);
        wait_result();
        check("n1_result", result, 8'hFB);
        consume();

        // abort in WAIT together with start
        job_el[0] = 1; job_el[1] = 2; job_el[2] = 3; job_el[3] = 4;
        load_job(2, 1'b0, 4);
        void'(exp_q.pop_back());
        repeat (2) @(posedge clock);
        #1;
        abort = 1'b1; start = 1'b1; size_in = 8'd2;
        @(posedge clock); #1;
        abort = 1'b0; start = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_ready", elem_ready, 1'b0);
        check("abort_size_kept", size, 8'd2);
        seen = 0;
        repeat (DL + 4) begin
            if (result_valid) seen++;
            @(posedge clock); #1;
        end
        check("abort_no_valid", seen, 0);
        load_job(2, 1'b0, 4);
        wait_result();
        check("post_abort_result", result, 8'hFE);
        consume();

        repeat (2) @(posedge clock);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
